fft16_top: RTL and testbench
============================

FFT16_TOP -- requirements
Module: fft16_top

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16: bit width of every real/imaginary sample, two's complement.
REQ-002 SHALL have parameter FRACTION, default 8: fractional bits of the fixed-point format (Q8.8 at defaults).
REQ-003 SHALL have one clock and an asynchronous, active-high reset: i_clk input 1 (rising edge); i_rst input 1 (asynchronous, active-high).
REQ-004 SHALL have input STAGES, 3 bits: number of radix-2 stages to execute. Legal value is 4; 0 or values above 4 SHALL be treated as 4.
REQ-005 SHALL have inputs inK_re and inK_im, K = 0..15, each WORD_SIZE bits: complex time-domain sample K.
REQ-006 SHALL have outputs outK_re and outK_im, K = 0..15, each WORD_SIZE bits, registered: complex frequency bin K in natural order.
REQ-007 SHALL have output o_FFT_cycle_done, 1 bit, registered: one-cycle pulse marking that new outK values are valid.

Function
REQ-008 SHALL compute the 16-point forward DFT X[k] = sum over n of x[n]·W16^(nk), with W16 = e^(-j2π/16), using radix-2 decimation in time.
REQ-009 SHALL use an iterative datapath with three FSM states: LOAD, STAGE, DONE.
- LOAD: captures all 32 inputs into working registers in bit-reversed index order (working[rev4(n)] = x[n]); stage counter = 1.
- STAGE: performs all 8 butterflies of one stage per clock; stage s has span 2^(s-1). Moves to DONE after the stage numbered STAGES (effective value) completes.
- DONE: copies the working registers to outK in natural order, pulses o_FFT_cycle_done for exactly one cycle, returns to LOAD.
REQ-010 SHALL run free: a new transform starts automatically every 6 clocks while i_rst is low.
REQ-011 SHALL sample inputs only on the LOAD edge, which is the 1st rising edge after reset release. Input changes at other times SHALL NOT affect the transform in progress.
REQ-012 SHALL update outK and raise o_FFT_cycle_done on the 6th rising edge after reset release, and every 6 edges thereafter. outK SHALL hold their values between DONE cycles.
REQ-013 SHALL form butterflies as A' = A + W·B and B' = A − W·B. The twiddle for stage s, butterfly position p within its group, is W16^(p·16/2^s).
REQ-014 SHALL store twiddles as constants in Q(WORD_SIZE−FRACTION).FRACTION. At defaults: cos terms 256, 237, 181, 98, 0 for k = 0..4, with symmetric signs for k = 5..7, and the imaginary part = −sin.
REQ-015 SHALL multiply using full 2·WORD_SIZE-bit signed products, sum the products, then arithmetic-shift right by FRACTION (truncation toward −∞), keeping the low WORD_SIZE bits.
REQ-016 SHALL perform additions and subtractions at WORD_SIZE bits with two's-complement wrap-around. No saturation and no per-stage scaling.
REQ-017 SHALL be exact for multiplication by W^0 (value 2^FRACTION) and W^4 (−j).

Reset
REQ-018 SHALL, while i_rst is high, immediately force all outK_re/outK_im to 0, o_FFT_cycle_done to 0, the working registers to 0, and the FSM to LOAD with the stage counter at 1.
REQ-019 SHALL, when reset is asserted mid-transform, discard the partial result. After release it SHALL restart at LOAD per REQ-011/REQ-012.

Verification
REQ-020 Reset check: hold i_rst high for 5 clocks -> all 32 outputs are 0x0000 and o_FFT_cycle_done is 0.
REQ-021 Impulse: in0 = 0x0100 + j0, all other inputs 0, STAGES = 4 -> after the done pulse, every outK_re = 0x0100 and every outK_im = 0x0000.
REQ-022 DC: every inK_re = 0x0100, every inK_im = 0 -> out0_re = 0x1000; all other outputs 0x0000.
REQ-023 Sparse mix: in0 = 0x0100 + j0x00C9, in1 = 0x0300 + j0x00C9, in3 = 0x0500 + j0x00C9, in7 = 0x0200 + j0x00C9, all others 0.
- Required: out0 = 0x0B00 + j0x0324 and out8 = 0xF700 + j0xFE6E.
- Remaining bins match a floating-point DFT within ±4 LSB.
REQ-024 Timing: release reset, then count rising edges -> o_FFT_cycle_done is high only after edges 6, 12, 18, …, each time for one clock. Inputs changed on edge 3 do not alter the first result.
REQ-025 Mid-run reset: assert i_rst during a STAGE cycle -> outputs and done go to 0 immediately, without waiting for a clock edge. The first done pulse after release occurs 6 edges later with a correct result.

Source files
------------

// File: rtl/fft16_top.sv
// fft16_top: iterative 16-point radix-2 DIT FFT.
// Load in bit-reversed order, run the butterfly stages, then register the bins.

module fft16_top #(
  parameter int WORD_SIZE = 16,
  parameter int FRACTION  = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [2:0]           STAGES,
  input  logic [WORD_SIZE-1:0] in0_re,
  input  logic [WORD_SIZE-1:0] in0_im,
  input  logic [WORD_SIZE-1:0] in1_re,
  input  logic [WORD_SIZE-1:0] in1_im,
  input  logic [WORD_SIZE-1:0] in2_re,
  input  logic [WORD_SIZE-1:0] in2_im,
  input  logic [WORD_SIZE-1:0] in3_re,
  input  logic [WORD_SIZE-1:0] in3_im,
  input  logic [WORD_SIZE-1:0] in4_re,
  input  logic [WORD_SIZE-1:0] in4_im,
  input  logic [WORD_SIZE-1:0] in5_re,
  input  logic [WORD_SIZE-1:0] in5_im,
  input  logic [WORD_SIZE-1:0] in6_re,
  input  logic [WORD_SIZE-1:0] in6_im,
  input  logic [WORD_SIZE-1:0] in7_re,
  input  logic [WORD_SIZE-1:0] in7_im,
  input  logic [WORD_SIZE-1:0] in8_re,
  input  logic [WORD_SIZE-1:0] in8_im,
  input  logic [WORD_SIZE-1:0] in9_re,
  input  logic [WORD_SIZE-1:0] in9_im,
  input  logic [WORD_SIZE-1:0] in10_re,
  input  logic [WORD_SIZE-1:0] in10_im,
  input  logic [WORD_SIZE-1:0] in11_re,
  input  logic [WORD_SIZE-1:0] in11_im,
  input  logic [WORD_SIZE-1:0] in12_re,
  input  logic [WORD_SIZE-1:0] in12_im,
  input  logic [WORD_SIZE-1:0] in13_re,
  input  logic [WORD_SIZE-1:0] in13_im,
  input  logic [WORD_SIZE-1:0] in14_re,
  input  logic [WORD_SIZE-1:0] in14_im,
  input  logic [WORD_SIZE-1:0] in15_re,
  input  logic [WORD_SIZE-1:0] in15_im,
  output logic [WORD_SIZE-1:0] out0_re,
  output logic [WORD_SIZE-1:0] out0_im,
  output logic [WORD_SIZE-1:0] out1_re,
  output logic [WORD_SIZE-1:0] out1_im,
  output logic [WORD_SIZE-1:0] out2_re,
  output logic [WORD_SIZE-1:0] out2_im,
  output logic [WORD_SIZE-1:0] out3_re,
  output logic [WORD_SIZE-1:0] out3_im,
  output logic [WORD_SIZE-1:0] out4_re,
  output logic [WORD_SIZE-1:0] out4_im,
  output logic [WORD_SIZE-1:0] out5_re,
  output logic [WORD_SIZE-1:0] out5_im,
  output logic [WORD_SIZE-1:0] out6_re,
  output logic [WORD_SIZE-1:0] out6_im,
  output logic [WORD_SIZE-1:0] out7_re,
  output logic [WORD_SIZE-1:0] out7_im,
  output logic [WORD_SIZE-1:0] out8_re,
  output logic [WORD_SIZE-1:0] out8_im,
  output logic [WORD_SIZE-1:0] out9_re,
  output logic [WORD_SIZE-1:0] out9_im,
  output logic [WORD_SIZE-1:0] out10_re,
  output logic [WORD_SIZE-1:0] out10_im,
  output logic [WORD_SIZE-1:0] out11_re,
  output logic [WORD_SIZE-1:0] out11_im,
  output logic [WORD_SIZE-1:0] out12_re,
  output logic [WORD_SIZE-1:0] out12_im,
  output logic [WORD_SIZE-1:0] out13_re,
  output logic [WORD_SIZE-1:0] out13_im,
  output logic [WORD_SIZE-1:0] out14_re,
  output logic [WORD_SIZE-1:0] out14_im,
  output logic [WORD_SIZE-1:0] out15_re,
  output logic [WORD_SIZE-1:0] out15_im,
  output logic                 o_FFT_cycle_done
);

  localparam int W = WORD_SIZE;

  typedef logic signed [W-1:0] word_t;
  typedef logic signed [2*W:0] acc_t;
  typedef logic [15:0][W-1:0]  bank_t;
  typedef enum logic [1:0] {LOAD, STAGE, DONE} state_t;

  state_t     state, state_nx;
  logic [2:0] stage, stage_lim, stage_eff;
  bank_t      x_re, x_im;
  bank_t      wk_re, wk_im;
  bank_t      bf_re, bf_im;
  bank_t      y_re, y_im;

  assign x_re = {in15_re, in14_re, in13_re, in12_re,
                 in11_re, in10_re, in9_re, in8_re,
                 in7_re, in6_re, in5_re, in4_re,
                 in3_re, in2_re, in1_re, in0_re};
  assign x_im = {in15_im, in14_im, in13_im, in12_im,
                 in11_im, in10_im, in9_im, in8_im,
                 in7_im, in6_im, in5_im, in4_im,
                 in3_im, in2_im, in1_im, in0_im};

  assign {out15_re, out14_re, out13_re, out12_re,
          out11_re, out10_re, out9_re, out8_re,
          out7_re, out6_re, out5_re, out4_re,
          out3_re, out2_re, out1_re, out0_re} = y_re;
  assign {out15_im, out14_im, out13_im, out12_im,
          out11_im, out10_im, out9_im, out8_im,
          out7_im, out6_im, out5_im, out4_im,
          out3_im, out2_im, out1_im, out0_im} = y_im;

  // Anything outside 1..4 runs the full four stages.
  assign stage_eff = (STAGES == 3'd0 || STAGES > 3'd4) ? 3'd4 : STAGES;

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  // cos(2*pi*k/16) in Q.16, k in -8..8
  function automatic int q16_cos(input int k);
    int m;
    int q;
    m = (k < 0) ? -k : k;
    case (m)
      0:       q = 65536;
      1:       q = 60547;
      2:       q = 46341;
      3:       q = 25080;
      4:       q = 0;
      5:       q = -25080;
      6:       q = -46341;
      7:       q = -60547;
      default: q = -65536;
    endcase
    return q;
  endfunction

  // Round Q.16 down to Q.FRACTION
  function automatic word_t to_q(input int q);
    int r;
    r = (q + (1 <<< (15 - FRACTION))) >>> (16 - FRACTION);
    return word_t'(r);
  endfunction

  function automatic word_t tw_re(input int k);
    return to_q(q16_cos(k));
  endfunction

  // Imaginary part is -sin, and sin(k) = cos(4-k)
  function automatic word_t tw_im(input int k);
    return -to_q(q16_cos(4 - k));
  endfunction

  // Next-state logic for the load/stage/done sequence
  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    state_nx = STAGE;
      STAGE:   if (stage == stage_lim) state_nx = DONE;
      DONE:    state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // All eight butterflies of the current stage
  always_comb begin
    logic [3:0] h, p, a, c, bb;
    logic [1:0] sh;
    logic [2:0] k;
    word_t      ar, ai, br, bi, wr, wi, mr, mi;
    acc_t       prod_r, prod_i;
    bf_re  = wk_re;
    bf_im  = wk_im;
    h      = 4'd8;
    sh     = 2'd0;
    p      = '0;
    a      = '0;
    c      = '0;
    bb     = '0;
    k      = '0;
    ar     = '0;
    ai     = '0;
    br     = '0;
    bi     = '0;
    wr     = '0;
    wi     = '0;
    mr     = '0;
    mi     = '0;
    prod_r = '0;
    prod_i = '0;
    unique case (stage)
      3'd1:    begin h = 4'd1; sh = 2'd3; end
      3'd2:    begin h = 4'd2; sh = 2'd2; end
      3'd3:    begin h = 4'd4; sh = 2'd1; end
      default: begin h = 4'd8; sh = 2'd0; end
    endcase
    for (int b = 0; b < 8; b++) begin
      bb = 4'(b);
      p  = bb & (h - 4'd1);
      a  = ((bb & ~(h - 4'd1)) << 1) | p;
      c  = a | h;
      k  = 3'(p << sh);
      ar = word_t'(wk_re[a]);
      ai = word_t'(wk_im[a]);
      br = word_t'(wk_re[c]);
      bi = word_t'(wk_im[c]);
      wr = tw_re(int'(k));
      wi = tw_im(int'(k));
      prod_r = acc_t'(wr) * acc_t'(br)
             - acc_t'(wi) * acc_t'(bi);
      prod_i = acc_t'(wr) * acc_t'(bi)
             + acc_t'(wi) * acc_t'(br);
      mr = word_t'(prod_r >>> FRACTION);
      mi = word_t'(prod_i >>> FRACTION);
      bf_re[a] = ar + mr;
      bf_im[a] = ai + mi;
      bf_re[c] = ar - mr;
      bf_im[c] = ai - mi;
    end
  end

  // State, working bank and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state            <= LOAD;
      stage            <= 3'd1;
      stage_lim        <= 3'd4;
      wk_re            <= '0;
      wk_im            <= '0;
      y_re             <= '0;
      y_im             <= '0;
      o_FFT_cycle_done <= 1'b0;
    end else begin
      state            <= state_nx;
      o_FFT_cycle_done <= 1'b0;
      unique case (state)
        LOAD: begin
          for (int n = 0; n < 16; n++) begin
            wk_re[rev4(4'(n))] <= x_re[n];
            wk_im[rev4(4'(n))] <= x_im[n];
          end
          stage     <= 3'd1;
          stage_lim <= stage_eff;
        end
        STAGE: begin
          wk_re <= bf_re;
          wk_im <= bf_im;
          stage <= stage + 3'd1;
        end
        DONE: begin
          y_re             <= wk_re;
          y_im             <= wk_im;
          o_FFT_cycle_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft16_top.sv
// tb_fft16_top: table of transforms fed through a scoreboard queue,
// plus reset, timing and hold checks for the free-running FFT.

module tb_fft16_top;

  typedef struct {
    int               id;
    logic [2:0]       stg;
    logic [15:0][15:0] xr, xi, er, ei;
    int               tol;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       stg;
  logic [15:0][15:0] xr, xi;
  wire  [15:0][15:0] yr, yi;
  wire              done;

  vec_t tbl[6];
  vec_t sbq[$];
  vec_t last;
  bit   have_last;
  bit   run;
  int   ecnt;
  int   nerr;
  int   nchk;

  fft16_top #(.WORD_SIZE(16), .FRACTION(8)) dut (
    .i_clk(clk), .i_rst(rst), .STAGES(stg),
    .in0_re(xr[0]),   .in0_im(xi[0]),
    .in1_re(xr[1]),   .in1_im(xi[1]),
    .in2_re(xr[2]),   .in2_im(xi[2]),
    .in3_re(xr[3]),   .in3_im(xi[3]),
    .in4_re(xr[4]),   .in4_im(xi[4]),
    .in5_re(xr[5]),   .in5_im(xi[5]),
    .in6_re(xr[6]),   .in6_im(xi[6]),
    .in7_re(xr[7]),   .in7_im(xi[7]),
    .in8_re(xr[8]),   .in8_im(xi[8]),
    .in9_re(xr[9]),   .in9_im(xi[9]),
    .in10_re(xr[10]), .in10_im(xi[10]),
    .in11_re(xr[11]), .in11_im(xi[11]),
    .in12_re(xr[12]), .in12_im(xi[12]),
    .in13_re(xr[13]), .in13_im(xi[13]),
    .in14_re(xr[14]), .in14_im(xi[14]),
    .in15_re(xr[15]), .in15_im(xi[15]),
    .out0_re(yr[0]),   .out0_im(yi[0]),
    .out1_re(yr[1]),   .out1_im(yi[1]),
    .out2_re(yr[2]),   .out2_im(yi[2]),
    .out3_re(yr[3]),   .out3_im(yi[3]),
    .out4_re(yr[4]),   .out4_im(yi[4]),
    .out5_re(yr[5]),   .out5_im(yi[5]),
    .out6_re(yr[6]),   .out6_im(yi[6]),
    .out7_re(yr[7]),   .out7_im(yi[7]),
    .out8_re(yr[8]),   .out8_im(yi[8]),
    .out9_re(yr[9]),   .out9_im(yi[9]),
    .out10_re(yr[10]), .out10_im(yi[10]),
    .out11_re(yr[11]), .out11_im(yi[11]),
    .out12_re(yr[12]), .out12_im(yi[12]),
    .out13_re(yr[13]), .out13_im(yi[13]),
    .out14_re(yr[14]), .out14_im(yi[14]),
    .out15_re(yr[15]), .out15_im(yi[15]),
    .o_FFT_cycle_done(done)
  );

  initial forever #5 clk = ~clk;

  // Floating-point reference DFT, rounded to the nearest LSB
  function automatic void ref_dft(
    input  logic [15:0][15:0] ir, ii,
    output logic [15:0][15:0] orr, oi
  );
    real sr, si, ang, a, b;
    orr = '0;
    oi  = '0;
    for (int k = 0; k < 16; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 16; n++) begin
        ang = 2.0 * 3.14159265358979 * real'(n * k) / 16.0;
        a   = real'($signed(ir[n]));
        b   = real'($signed(ii[n]));
        sr  = sr + a * $cos(ang) + b * $sin(ang);
        si  = si + b * $cos(ang) - a * $sin(ang);
      end
      orr[k] = 16'(int'(sr));
      oi[k]  = 16'(int'(si));
    end
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp, input int tol);
    int d;
    nchk++;
    d = int'($signed(act)) - int'($signed(exp));
    if (d < 0) d = -d;
    if (d > tol) begin
      nerr++;
      $display("FAIL %s: got %h want %h (tol %0d)", nm, act, exp, tol);
    end
  endtask

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input vec_t e);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("v%0d bin%0d re", e.id, k), yr[k], e.er[k], e.tol);
      chk($sformatf("v%0d bin%0d im", e.id, k), yi[k], e.ei[k], e.tol);
    end
  endtask

  task automatic apply(input vec_t v);
    xr  = v.xr;
    xi  = v.xi;
    stg = v.stg;
    sbq.push_back(v);
  endtask

  // Monitor: done timing, scoreboard pops, output hold between pulses
  always @(negedge clk) begin
    if (!run) begin
      ecnt      = 0;
      have_last = 1'b0;
    end else begin
      ecnt++;
      chk_bit($sformatf("done_edge%0d", ecnt), done, (ecnt % 6) == 0);
      if (done === 1'b1) begin
        nchk++;
        if (sbq.size() == 0) begin
          nerr++;
          $display("FAIL sb_empty: got done pulse, want queued result");
        end else begin
          last      = sbq.pop_front();
          have_last = 1'b1;
          chk_vec(last);
          if (last.id == 2) begin
            chk("sparse out0 re", yr[0], 16'h0B00, 0);
            chk("sparse out0 im", yi[0], 16'h0324, 0);
            chk("sparse out8 re", yr[8], 16'hF700, 0);
            chk("sparse out8 im", yi[8], 16'hFE6E, 0);
          end
        end
      end
      if ((ecnt % 6) == 3 && have_last) begin
        chk($sformatf("hold%0d re5", ecnt), yr[5], last.er[5], last.tol);
        chk($sformatf("hold%0d im5", ecnt), yi[5], last.ei[5], last.tol);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    stg  = 3'd4;
    xr   = '0;
    xi   = '0;
    run  = 1'b0;
    nerr = 0;
    nchk = 0;

    for (int i = 0; i < 6; i++) begin
      tbl[i].id  = i;
      tbl[i].stg = 3'd4;
      tbl[i].xr  = '0;
      tbl[i].xi  = '0;
      tbl[i].er  = '0;
      tbl[i].ei  = '0;
      tbl[i].tol = 0;
    end
    // impulse
    tbl[0].xr[0] = 16'h0100;
    for (int k = 0; k < 16; k++) tbl[0].er[k] = 16'h0100;
    // DC
    for (int n = 0; n < 16; n++) tbl[1].xr[n] = 16'h0100;
    tbl[1].er[0] = 16'h1000;
    // sparse mix
    tbl[2].xr[0] = 16'h0100;
    tbl[2].xr[1] = 16'h0300;
    tbl[2].xr[3] = 16'h0500;
    tbl[2].xr[7] = 16'h0200;
    tbl[2].xi[0] = 16'h00C9;
    tbl[2].xi[1] = 16'h00C9;
    tbl[2].xi[3] = 16'h00C9;
    tbl[2].xi[7] = 16'h00C9;
    tbl[2].tol   = 4;
    ref_dft(tbl[2].xr, tbl[2].xi, tbl[2].er, tbl[2].ei);
    // small random signals, with out-of-range STAGES codes
    tbl[3].stg = 3'd0;
    tbl[4].stg = 3'd7;
    tbl[5].stg = 3'd5;
    for (int i = 3; i < 6; i++) begin
      for (int n = 0; n < 16; n++) begin
        tbl[i].xr[n] = 16'(int'($urandom_range(128)) - 64);
        tbl[i].xi[n] = 16'(int'($urandom_range(128)) - 64);
      end
      tbl[i].tol = 4;
      ref_dft(tbl[i].xr, tbl[i].xi, tbl[i].er, tbl[i].ei);
    end

    // held in reset for 5 clocks
    repeat (5) @(posedge clk);
    #1;
    nchk++;
    if (yr !== '0 || yi !== '0) begin
      nerr++;
      $display("FAIL reset_out: got %h_%h want all zero", yr[0], yi[0]);
    end
    chk_bit("reset_done", done, 1'b0);

    apply(tbl[0]);
    @(negedge clk);
    #1;
    rst = 1'b0;
    run = 1'b1;

    // new inputs land after edge 3 of each period
    for (int v = 1; v < 6; v++) begin
      repeat ((v == 1) ? 3 : 6) @(posedge clk);
      #1;
      apply(tbl[v]);
    end

    for (int i = 0; i < 40 && sbq.size() != 0; i++) @(posedge clk);
    nchk++;
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end

    // reset in the middle of a stage cycle
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    run = 1'b0;
    #1;
    nchk++;
    if (yr !== '0 || yi !== '0) begin
      nerr++;
      $display("FAIL midreset_out: got %h_%h want all zero", yr[0], yi[0]);
    end
    chk_bit("midreset_done", done, 1'b0);

    sbq.delete();
    apply(tbl[1]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
    run = 1'b1;

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clk);
    nchk++;
    if (sbq.size() != 0) begin
      nerr++;
      $display("FAIL after_reset: got %0d pending want 0", sbq.size());
    end
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
